echo_delay: RTL
===============

ECHO_DELAY -- requirements
Module: echo_delay

Interface
REQ-001 Parameter DATA_W, default 10, sample width in offset-binary (mid-scale = 2^(DATA_W-1)).
REQ-002 Parameter ADDR_W, default 13, delay-buffer address width; buffer depth is 2^ADDR_W samples (8192 = 0.82 s at 10 kHz).
REQ-003 sysclk, input, 1, system clock (50 MHz); the block has this single clock domain only.
REQ-004 reset, input, 1, asynchronous, active-high reset.
REQ-005 data_in, input, DATA_W, ADC sample in offset binary.
REQ-006 data_valid, input, 1, one-cycle strobe; data_in is valid in that cycle.
REQ-007 delay, input, ADDR_W, echo delay in samples; 0 disables the echo.
REQ-008 data_out, output, DATA_W, processed sample in offset binary, held between updates.
REQ-009 out_valid, output, 1, one-cycle strobe when data_out updates.
REQ-010 overrun, output, 1, sticky flag: a data_valid arrived while busy.

Function
REQ-011 Buffer: single-port synchronous RAM, 2^ADDR_W x DATA_W, with 1-cycle read latency; write pointer wr_ptr is ADDR_W bits.
REQ-012 FSM states: IDLE, RD, RD_WAIT, CALC, WR, OUT.
- IDLE -> RD on data_valid; data_in and delay are captured in that cycle.
- RD: RAM address = wr_ptr - delay (mod 2^ADDR_W).
- RD_WAIT: RAM data is captured.
- CALC: the arithmetic of REQ-014 is performed.
- WR: the captured sample is written at wr_ptr, and wr_ptr increments with wrap 2^ADDR_W-1 -> 0.
- OUT: data_out and out_valid are driven; the FSM returns to IDLE.
REQ-013 Latency: out_valid asserts exactly 5 sysclk cycles after the data_valid cycle (data_valid at cycle 0 -> out_valid at cycle 5).
REQ-014 Arithmetic: x = data_in - 512 and e = delayed - 512 (signed, DATA_W+1 bits); y = x + (e >>> 1) with arithmetic shift; y saturates to [-512, +511]; data_out = y + 512.
REQ-015 Echo term e is forced to 0 when delay == 0 or when fill < delay.
- fill is a saturating counter of samples written since reset, max 2^ADDR_W-1.
- This prevents garbage from uninitialised RAM reaching the output.
REQ-016 delay is sampled only in the data_valid cycle; changes at other times take effect on the next sample.
REQ-017 A data_valid asserted in any state other than IDLE is dropped and sets overrun; the sample in progress completes normally.
REQ-018 A data_valid in the same cycle that OUT returns to IDLE is dropped; samples are accepted only while in IDLE.
REQ-019 overrun clears only on reset.
REQ-020 When delay = 2^ADDR_W-1, the read address is wr_ptr+1, i.e. the oldest stored sample.
REQ-021 With delay fixed at D > 0 and fill ≥ D, the echo term for sample n is sample n-D.

Reset
REQ-022 reset asserted forces, asynchronously: state IDLE, wr_ptr 0, fill 0, data_out 512 (10'h200), out_valid 0, overrun 0.
REQ-023 RAM contents are not cleared on reset; REQ-015 masks them.
REQ-024 Reset asserted mid-sample (any non-IDLE state) abandons that sample: no out_valid is produced and no RAM write occurs if WR has not yet been reached.
REQ-025 The first data_valid is accepted in the first cycle after reset deasserts.

Verification
REQ-026 Reset then idle -> data_out = 0x200, out_valid = 0, overrun = 0.
REQ-027 delay=0; samples 0x300, 0x000, 0x3FF at 10 kHz ticks -> data_out 0x300, 0x000, 0x3FF, each with out_valid exactly 5 cycles after its data_valid.
REQ-028 delay=2; sample sequence 0x300, 0x200, 0x200, 0x200.
- Expected outputs: 0x300, 0x200, 0x280, 0x200.
- The echo is +256>>1 = +128 on the third sample; the first two outputs have no echo because fill < 2.
REQ-029 Saturation, delay=1; samples 0x3FF, 0x3FF -> second output = 0x3FF (y = 511 + 255 clipped to 511).
- Repeat with samples 0x000, 0x000 -> second output = 0x000 (clipped to -512).
REQ-030 Wrap-around, delay=3; write 8195 samples with value 0x200 + (n mod 4).
- Across the wr_ptr 8191 -> 0 wrap, the echo must equal sample n-3 with no discontinuity.
REQ-031 Back-to-back strobes and reset mid-sample:
- Assert data_valid for 2 consecutive cycles -> one out_valid, overrun = 1.
- Then assert reset in state CALC -> no out_valid, overrun = 0, data_out = 0x200.

Source files
------------

// File: rtl/echo_delay.sv
// Echo/delay effect: each strobed sample is mixed with half of the sample taken
// `delay` samples earlier, using a single-port delay RAM and a six-state sequencer.
module echo_delay #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 13
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [ADDR_W-1:0] delay,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              overrun
);

  // Two guard bits: x + e/2 spans 1.5x full scale before clipping.
  localparam int SW = DATA_W + 2;
  localparam logic [DATA_W-1:0]    MID   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0] Y_MAX = SW'((1 << (DATA_W-1)) - 1);
  localparam logic signed [SW-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, CALC, WR, OUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] sample_q, delayed_q, y_q, ram_rdata;
  logic [ADDR_W-1:0] delay_q, wr_ptr, fill, ram_addr;
  logic              echo_en_q;
  logic              ram_we;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign ram_we   = (state == WR);
  assign ram_addr = ram_we ? wr_ptr : wr_ptr - delay_q;

  // No reset on the array: stale contents are masked by the fill check.
  always_ff @(posedge sysclk) begin
    if (ram_we) mem[ram_addr] <= sample_q;
    ram_rdata <= mem[ram_addr];
  end

  logic signed [SW-1:0] x_s, e_s, y_s;
  logic signed [SW-1:0] y_sat;
  logic [DATA_W-1:0]    y_ob;

  always_comb begin
    // Offset binary -> two's complement is an MSB flip plus sign extension.
    x_s = {{2{~sample_q[DATA_W-1]}}, ~sample_q[DATA_W-1], sample_q[DATA_W-2:0]};
    e_s = '0;
    if (echo_en_q)
      e_s = {{2{~delayed_q[DATA_W-1]}}, ~delayed_q[DATA_W-1], delayed_q[DATA_W-2:0]};
    y_s = x_s + (e_s >>> 1);
    y_sat = y_s;
    if (y_s > Y_MAX)      y_sat = Y_MAX;
    else if (y_s < Y_MIN) y_sat = Y_MIN;
    y_ob = {~y_sat[DATA_W-1], y_sat[DATA_W-2:0]};
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      data_out  <= MID;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sample_q  <= '0;
      delayed_q <= '0;
      y_q       <= '0;
      delay_q   <= '0;
      echo_en_q <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (data_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (data_valid) begin
          sample_q <= data_in;
          delay_q  <= delay;
          state    <= RD;
        end
        RD: begin
          echo_en_q <= (delay_q != '0) && (fill >= delay_q);
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          delayed_q <= ram_rdata;
          state     <= CALC;
        end
        CALC: begin
          y_q   <= y_ob;
          state <= WR;
        end
        WR: begin
          wr_ptr    <= wr_ptr + 1'b1;
          if (fill != '1) fill <= fill + 1'b1;
          data_out  <= y_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
